// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions over req/ack, resolves control flow and steps the program counter
module fetch_sequencer #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_add,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              zero_flag,
   input  logic              exec_done,
   output logic              pc_inc,
   output logic              jmp,
   output logic [ADDR_W-1:0] jmp_add,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              halted,
   output logic              fault,
   output logic [7:0]        retired
);
   typedef enum logic [2:0] {FETCH, WAIT, DECODE, EXEC, ADV, HALT, FAULT} state_t;
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic       take_jmp;
   logic       jump_now;
   logic [2:0] opcode;
   assign opcode      = instr[DATA_W-1 -: 3];
   assign jump_now    = opcode == 3'b001 || (opcode == 3'b010 && zero_flag);
   assign mem_req     = state == WAIT;
   assign pc_inc      = state == ADV && !take_jmp;
   assign jmp         = state == ADV && take_jmp;
   assign instr_valid = state == EXEC;
   assign halted      = state == HALT;
   assign fault       = state == FAULT;
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end
   // next-state decode; the last WAIT cycle without ack moves to FAULT
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = WAIT;
         WAIT:    state_nxt = mem_ack ? DECODE : (cnt == TO_LAST ? FAULT : WAIT);
         DECODE:  state_nxt = opcode == 3'b111 ? HALT : (opcode <= 3'b010 ? ADV : EXEC);
         EXEC:    state_nxt = exec_done ? ADV : EXEC;
         ADV:     state_nxt = FETCH;
         HALT:    state_nxt = HALT;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = FETCH;
      endcase
   end
   // address capture, instruction latch, jump decision, timeout and retire counters
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr <= '0;
         instr    <= '0;
         jmp_add  <= '0;
         take_jmp <= 1'b0;
         cnt      <= '0;
         retired  <= '0;
      end else begin
         if (state == FETCH) begin
            mem_addr <= pc_add;
            cnt      <= '0;
         end
         if (state == WAIT) begin
            if (mem_ack) instr <= mem_data;
            else         cnt   <= cnt + 4'd1;
         end
         if (state == DECODE) begin
            take_jmp <= jump_now;
            if (jump_now) jmp_add <= instr[ADDR_W-1:0] & ~ADDR_W'(3);
         end
         if (state == ADV) retired <= retired + 8'd1;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a memory model and a program counter model
module tb_fetch_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] pc_add;
   logic       mem_req;
   logic [4:0] mem_addr;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_data = 8'h00;
   logic       zero_flag = 1'b0;
   logic       exec_done = 1'b0;
   logic       pc_inc, jmp, instr_valid, halted, fault;
   logic [4:0] jmp_add;
   logic [7:0] instr;
   logic [7:0] retired;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .pc_add(pc_add), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .zero_flag(zero_flag), .exec_done(exec_done),
      .pc_inc(pc_inc), .jmp(jmp), .jmp_add(jmp_add), .instr(instr), .instr_valid(instr_valid),
      .halted(halted), .fault(fault), .retired(retired)
   );

   always #5 clk = ~clk;

   // program counter model driven by the sequencer's pulses
   logic [4:0] pc;
   assign pc_add = pc;
   always_ff @(posedge clk) begin
      if (rst)         pc <= '0;
      else if (jmp)    pc <= jmp_add;
      else if (pc_inc) pc <= pc + 5'd4;
   end

   typedef struct {
      int         kind;
      logic [4:0] target;
      int         delay;
      int         gap;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] mem[32];
   bit         zf[32];
   int         edly[32];
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         last = 0;
   int         iv_len = 0;
   int         cur_delay = 1;
   int         n_ret = 0;
   int         req_cyc = 0;
   logic [7:0] cur_instr = 8'h00;
   logic [4:0] exp_addr = 5'd0;
   logic [7:0] exp_ret = 8'd0;
   bit         no_ack = 1'b0;
   bit         halt_seen = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         mem[i]  = 8'h00;
         zf[i]   = 1'b0;
         edly[i] = 1;
      end
   endtask

   task automatic do_reset(input bit with_chk);
      rst = 1'b1;
      mem_ack = 1'b0;
      exec_done = 1'b0;
      repeat (2) @(negedge clk);
      if (with_chk) begin
         chk("rst_mem_req", mem_req, 0);
         chk("rst_pc_inc", pc_inc, 0);
         chk("rst_jmp", jmp, 0);
         chk("rst_instr_valid", instr_valid, 0);
         chk("rst_halted", halted, 0);
         chk("rst_fault", fault, 0);
         chk("rst_retired", retired, 0);
         chk("rst_instr", instr, 0);
         chk("rst_jmp_add", jmp_add, 0);
         chk("rst_mem_addr", mem_addr, 0);
      end
      rst = 1'b0;
      sbq.delete();
      exp_addr = 5'd0;
      exp_ret = 8'd0;
      iv_len = 0;
      n_ret = 0;
      req_cyc = 0;
      halt_seen = 1'b0;
      last = cyc - 1;
   endtask

   task automatic step();
      exp_t       e;
      logic [7:0] d;
      @(negedge clk);
      cyc++;
      zero_flag = zf[mem_addr];
      if (mem_req) req_cyc++;
      if (pc_inc || jmp) begin
         chk("pulse_excl", pc_inc & jmp, 0);
         if (sbq.size() == 0) chk("sb_empty_pulse", 1, 0);
         else begin
            e = sbq.pop_front();
            chk("pulse_kind", jmp, e.kind);
            if (jmp) chk("jmp_add", jmp_add, e.target);
            chk("pulse_gap", cyc - last, e.gap);
            chk("exec_len", iv_len, e.delay);
            chk("retired", retired, exp_ret);
         end
         exp_ret = exp_ret + 8'd1;
         n_ret++;
         last = cyc;
         iv_len = 0;
      end
      if (halted && !halt_seen) begin
         halt_seen = 1'b1;
         if (sbq.size() == 0) chk("sb_empty_halt", 1, 0);
         else begin
            e = sbq.pop_front();
            chk("halt_kind", e.kind, 2);
         end
      end
      if (instr_valid) begin
         iv_len++;
         chk("instr_hold", instr, cur_instr);
      end
      exec_done = instr_valid && iv_len >= cur_delay;
      if (mem_req && !no_ack) begin
         chk("fetch_addr", mem_addr, exp_addr);
         d = mem[mem_addr];
         mem_ack = 1'b1;
         mem_data = d;
         iv_len = 0;
         e.target = {d[4:2], 2'b00};
         e.delay = 0;
         e.gap = 4;
         case (d[7:5])
            3'b000:  e.kind = 0;
            3'b001:  e.kind = 1;
            3'b010:  e.kind = zf[mem_addr] ? 1 : 0;
            3'b111:  e.kind = 2;
            default: begin
               e.kind = 0;
               e.delay = edly[mem_addr];
               e.gap = 4 + edly[mem_addr];
               cur_instr = d;
               cur_delay = edly[mem_addr];
            end
         endcase
         exp_addr = e.kind == 1 ? e.target : exp_addr + 5'd4;
         sbq.push_back(e);
      end else begin
         mem_ack = 1'b0;
         mem_data = 8'($urandom);
      end
   endtask

   task automatic run_until(input int target, input int budget);
      int k = 0;
      while (n_ret < target && k < budget) begin
         step();
         k++;
      end
      chk("retire_budget", n_ret, target);
   endtask

   initial begin
      int k;
      // straight-line NOPs with address wrap 28 -> 0
      clear_mem();
      do_reset(1'b1);
      run_until(9, 60);
      chk("nop_wrap_addr", mem_addr, 0);

      // JMP at 8 to 12, JMP at 20 to 28, then wrap
      clear_mem();
      mem[8]  = 8'h2D;
      mem[20] = 8'h3F;
      do_reset(1'b0);
      run_until(8, 60);

      // JZ not taken, JZ taken, two execute ops, then HLT
      clear_mem();
      mem[0]  = 8'h50;
      mem[4]  = 8'h50;
      zf[4]   = 1'b1;
      mem[16] = 8'h60;
      edly[16] = 5;
      mem[20] = 8'h8B;
      edly[20] = 2;
      mem[24] = 8'hE0;
      do_reset(1'b0);
      k = 0;
      while (!halt_seen && k < 80) begin
         step();
         k++;
      end
      chk("halted", halted, 1);
      chk("halt_retired", retired, 4);
      req_cyc = 0;
      repeat (10) step();
      chk("halt_no_req", req_cyc, 0);
      chk("halt_sticky", halted, 1);

      // memory never answers: timeout fault, then reset recovers
      clear_mem();
      no_ack = 1'b1;
      do_reset(1'b0);
      k = 0;
      while (!fault && k < 40) begin
         step();
         k++;
      end
      chk("fault", fault, 1);
      chk("timeout_cycles", req_cyc, 15);
      chk("fault_req_low", mem_req, 0);
      repeat (3) step();
      chk("fault_sticky", fault, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("fault_cleared", fault, 0);
      chk("fault_rst_req", mem_req, 0);
      rst = 1'b0;
      step();
      chk("req_rise", mem_req, 1);

      // reset while stalled in WAIT after a jump
      clear_mem();
      mem[8] = 8'h2D;
      no_ack = 1'b0;
      do_reset(1'b0);
      run_until(4, 40);
      no_ack = 1'b1;
      k = 0;
      while (!mem_req && k < 10) begin
         step();
         k++;
      end
      chk("stall_req", mem_req, 1);
      repeat (2) step();
      chk("stall_jmp_add", jmp_add, 12);
      rst = 1'b1;
      @(negedge clk);
      chk("wait_rst_req", mem_req, 0);
      chk("wait_rst_retired", retired, 0);
      chk("wait_rst_jmp_add", jmp_add, 0);
      chk("wait_rst_mem_addr", mem_addr, 0);
      chk("wait_rst_instr", instr, 0);
      rst = 1'b0;
      no_ack = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-side partner of the program counter: drives its pc_inc, jmp and jmp_add inputs and consumes its 5-bit address output.
- For each address, fetches an 8-bit instruction from instruction memory over a req/ack handshake and decodes it.
- Resolves control flow (NOP, JMP, JZ, HLT) itself; hands all other opcodes to the execute stage and waits for completion.
- Sits between program_counter, instruction memory and the ALU/execute logic.

Parameters:
ADDR_W, 5, width of PC address and jump target
DATA_W, 8, instruction width; opcode = [DATA_W-1:DATA_W-3], operand = [ADDR_W-1:0]
TIMEOUT, 15, max cycles in WAIT without mem_ack before fault (4-bit counter)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
pc_add  in  ADDR_W  current address from program counter
mem_req  out  1  instruction read request
mem_addr  out  ADDR_W  read address, registered copy of pc_add
mem_ack  in  1  memory data valid this cycle
mem_data  in  DATA_W  instruction word, sampled when mem_ack=1
zero_flag  in  1  ALU zero flag, used by JZ
exec_done  in  1  execute stage finished current instruction
pc_inc  out  1  one-cycle pulse: PC += 4
jmp  out  1  one-cycle pulse: PC <= jmp_add
jmp_add  out  ADDR_W  jump target, valid while jmp=1
instr  out  DATA_W  latched instruction for execute stage
instr_valid  out  1  high while execute stage owns instr
halted  out  1  sticky: HLT decoded
fault  out  1  sticky: memory timeout
retired  out  8  count of completed instructions, wraps 255->0

Behaviour:
- Reset (rst=1 at edge, any state, mid-fetch included): state=FETCH. mem_req, pc_inc, jmp, instr_valid, halted and fault all 0. jmp_add, instr, mem_addr, retired and the timeout counter all 0. rst wins over every other input.
- States: FETCH, WAIT, DECODE, EXEC, ADV, HALT, FAULT.
- FETCH: mem_addr<=pc_add, mem_req<=1, clear timeout counter; -> WAIT.
- WAIT: mem_req held 1.
  - mem_ack=1: instr<=mem_data, mem_req<=0; -> DECODE. An ack arriving in the first WAIT cycle is accepted.
  - Otherwise counter+1. When counter reaches TIMEOUT with no ack: mem_req<=0, fault<=1; -> FAULT.
  - mem_ack outside WAIT is ignored.
- DECODE (opcode = instr[7:5]):
  - 000 NOP: -> ADV, increment.
  - 001 JMP: -> ADV, jump.
  - 010 JZ: jump if zero_flag=1, else increment. zero_flag is sampled in DECODE.
  - 111 HLT: halted<=1; -> HALT.
  - All other opcodes: instr_valid<=1; -> EXEC.
- EXEC: hold instr stable. When exec_done=1: instr_valid<=0; -> ADV, increment. No timeout in EXEC.
- ADV: exactly one of pc_inc or jmp is high for exactly this one cycle. retired+1. -> FETCH.
  - Jump target: jmp_add = {operand[4:2],2'b00}, forced word-aligned.
  - pc_inc and jmp are never high together.
  - The PC updates on the edge leaving ADV, so FETCH samples the new pc_add.
- Address wrap: PC 28 + 4 -> 0. The sequencer takes no special action.
- HALT, FAULT: terminal. All pulses 0, mem_req=0. Only rst exits.
- Latency, NOP with ack in first WAIT cycle: FETCH, WAIT, DECODE, ADV = 4 cycles per instruction.

Test Plan:
- Reset, then memory returns NOP (8'h00) with ack 1 cycle after req -> pc_inc pulses every 4 cycles; mem_addr runs 0,4,8,...,28,0; retired increments each ADV.
- At addr 8, mem_data=8'h2D (JMP, operand 13) -> jmp=1 for 1 cycle with jmp_add=12; next mem_addr=12; pc_inc stays 0 that cycle.
- JZ 8'h50: zero_flag=0 -> pc_inc pulse. zero_flag=1 -> jmp pulse with jmp_add=16.
- Opcode 011 with exec_done delayed 5 cycles -> instr_valid high 5 cycles and instr constant; exactly one pc_inc pulse after exec_done.
- mem_ack never asserted -> fault=1 after 15 WAIT cycles, mem_req drops. Assert rst -> fault=0, state=FETCH, mem_req rises next cycle.
- HLT 8'hE0 -> halted=1, no further mem_req. rst asserted during WAIT of a later run -> mem_req=0 next cycle, retired=0.
